// File: rtl/generatore_scansione.sv
// generatore_scansione: raster scan timing generator.
// Walks a pixel position (X_CONTROLLO, Y_CONTROLLO) over a full frame that
// includes blanking, and decodes ATTIVO, HSYNC, VSYNC and INIZIO_QUADRO from
// the next-state position so every flag lines up with the coordinates it
// describes.
// Build option: define GEN_SCANSIONE_SYNC_POS_EN for active-high syncs;
// leave it undefined for active-low syncs.
module generatore_scansione #(
  parameter int H_ATTIVO = 1280,
  parameter int H_FRONT  = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BACK   = 248,
  parameter int V_ATTIVO = 1024,
  parameter int V_FRONT  = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 38
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  output logic [10:0] X_CONTROLLO,
  output logic [10:0] Y_CONTROLLO,
  output logic        ATTIVO,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        INIZIO_QUADRO
);

  localparam int H_TOT = H_ATTIVO + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_ATTIVO + V_FRONT + V_SYNC + V_BACK;

  // Both totals must fit the 11-bit coordinate ports.
  if (H_TOT > 2047) begin : g_h_tot_check
    $error("generatore_scansione: H_TOT exceeds 2047");
  end
  if (V_TOT > 2047) begin : g_v_tot_check
    $error("generatore_scansione: V_TOT exceeds 2047");
  end

  localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOT - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ATTIVO);
  localparam logic [10:0] V_VIS    = 11'(V_ATTIVO);
  localparam logic [10:0] HS_START = 11'(H_ATTIVO + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_ATTIVO + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ATTIVO + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_ATTIVO + V_FRONT + V_SYNC);

`ifdef GEN_SCANSIONE_SYNC_POS_EN
  localparam logic SYNC_ON  = 1'b1;
`else
  localparam logic SYNC_ON  = 1'b0;
`endif
  localparam logic SYNC_OFF = ~SYNC_ON;

  // Stage p0: next-state position (combinational)
  logic [10:0] x_p0;
  logic [10:0] y_p0;

  // Stage p1: registered position and flags
  logic [10:0] x_p1;
  logic [10:0] y_p1;
  logic        attivo_p1;
  logic        hsync_p1;
  logic        vsync_p1;
  logic        inizio_p1;

  function automatic logic in_range(input logic [10:0] v,
                                    input logic [10:0] lo,
                                    input logic [10:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  // Next position: horizontal step with line wrap, vertical step only on a line wrap.
  always_comb begin
    x_p0 = x_p1 + 11'd1;
    y_p0 = y_p1;
    if (x_p1 == H_LAST) begin
      x_p0 = 11'd0;
      y_p0 = (y_p1 == V_LAST) ? 11'd0 : y_p1 + 11'd1;
    end
  end

  // Position and flag registers; flags are decoded from the next position so they stay aligned.
  always_ff @(posedge CLK) begin
    if (RST) begin
      x_p1      <= H_LAST;
      y_p1      <= V_LAST;
      attivo_p1 <= 1'b0;
      hsync_p1  <= SYNC_OFF;
      vsync_p1  <= SYNC_OFF;
      inizio_p1 <= 1'b0;
    end else if (ENABLE) begin
      x_p1      <= x_p0;
      y_p1      <= y_p0;
      attivo_p1 <= (x_p0 < H_VIS) && (y_p0 < V_VIS);
      hsync_p1  <= in_range(x_p0, HS_START, HS_END) ? SYNC_ON : SYNC_OFF;
      vsync_p1  <= in_range(y_p0, VS_START, VS_END) ? SYNC_ON : SYNC_OFF;
      inizio_p1 <= (x_p0 == 11'd0) && (y_p0 == 11'd0);
    end else begin
      inizio_p1 <= 1'b0;
    end
  end

  assign X_CONTROLLO   = x_p1;
  assign Y_CONTROLLO   = y_p1;
  assign ATTIVO        = attivo_p1;
  assign HSYNC         = hsync_p1;
  assign VSYNC         = vsync_p1;
  assign INIZIO_QUADRO = inizio_p1;

endmodule

// File: tb/tb_generatore_scansione.sv
// Testbench for generatore_scansione: two instances (full 1280x1024 timing and
// a shrunken frame so whole frames fit in a short run) driven by the same
// stimulus, each checked against a linear-position reference model.
module tb_generatore_scansione;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en;

  logic [10:0] x0, y0, x1, y1;
  logic        a0, h0, v0, s0, a1, h1, v1, s1;

`ifdef GEN_SCANSIONE_SYNC_POS_EN
  localparam logic ON = 1'b1;
`else
  localparam logic ON = 1'b0;
`endif
  localparam logic OFF = ~ON;

  // Small frame geometry: H_TOT = 25, V_TOT = 16
  localparam int SH_A = 16, SH_F = 2, SH_S = 3, SH_B = 4;
  localparam int SV_A = 10, SV_F = 1, SV_S = 2, SV_B = 3;

  generatore_scansione dut0 (
    .CLK(clk), .RST(rst), .ENABLE(en),
    .X_CONTROLLO(x0), .Y_CONTROLLO(y0), .ATTIVO(a0),
    .HSYNC(h0), .VSYNC(v0), .INIZIO_QUADRO(s0)
  );

  generatore_scansione #(
    .H_ATTIVO(SH_A), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_ATTIVO(SV_A), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B)
  ) dut1 (
    .CLK(clk), .RST(rst), .ENABLE(en),
    .X_CONTROLLO(x1), .Y_CONTROLLO(y1), .ATTIVO(a1),
    .HSYNC(h1), .VSYNC(v1), .INIZIO_QUADRO(s1)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        att;
    logic        hs;
    logic        vs;
    logic        iq;
  } obs_t;

  obs_t q0[$];
  obs_t q1[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: linear position within the frame, 0 .. H_TOT*V_TOT-1
  int pos0;
  int pos1;

  // Model: the frame is a single ring of H_TOT*V_TOT positions; X and Y are
  // the column/row of the ring index, flags follow from the geometry.
  function automatic obs_t model_step(input int ha, input int hf, input int hsy, input int hb,
                                      input int va, input int vf, input int vsy, input int vb,
                                      inout int pos, input logic r, input logic e);
    int   ht, vt, x, y;
    obs_t o;
    ht = ha + hf + hsy + hb;
    vt = va + vf + vsy + vb;
    o.iq = 1'b0;
    if (r) begin
      pos = ht * vt - 1;
    end else if (e) begin
      pos  = (pos + 1) % (ht * vt);
      o.iq = (pos == 0);
    end
    x = pos % ht;
    y = pos / ht;
    o.x   = 11'(x);
    o.y   = 11'(y);
    o.att = (x < ha) && (y < va);
    o.hs  = (x >= ha + hf && x < ha + hf + hsy) ? ON : OFF;
    o.vs  = (y >= va + vf && y < va + vf + vsy) ? ON : OFF;
    return o;
  endfunction

  // Apply one cycle of stimulus and queue the response expected after the next edge.
  task automatic drive(input logic r, input logic e);
    rst = r;
    en  = e;
    q0.push_back(model_step(1280, 48, 112, 248, 1024, 1, 3, 38, pos0, r, e));
    q1.push_back(model_step(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, pos1, r, e));
    @(negedge clk);
  endtask

  task automatic compare(input string name, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got x=%0d y=%0d att=%b hs=%b vs=%b iq=%b required x=%0d y=%0d att=%b hs=%b vs=%b iq=%b",
               name, got.x, got.y, got.att, got.hs, got.vs, got.iq,
               exp.x, exp.y, exp.att, exp.hs, exp.vs, exp.iq);
    end
  endtask

  // Monitor: after each edge, pop expected responses and compare.
  always @(posedge clk) begin
    obs_t e0, e1, g0, g1;
    #1;
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      g0 = {x0, y0, a0, h0, v0, s0};
      compare("full_frame", g0, e0);
      // Fixed-value spot checks from the 1280x1024 timing
      if (x0 === 11'd1400) begin
        n_checks++;
        if (h0 !== ON) begin
          n_fail++;
          $display("FAIL hsync_at_1400 got %b required %b", h0, ON);
        end
      end
      if (x0 === 11'd1687 && y0 === 11'd1065) begin
        n_checks++;
        if ({a0, h0, v0, s0} !== {1'b0, OFF, OFF, 1'b0}) begin
          n_fail++;
          $display("FAIL last_pos_flags got att=%b hs=%b vs=%b iq=%b required att=0 hs=%b vs=%b iq=0",
                   a0, h0, v0, s0, OFF, OFF);
        end
      end
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      g1 = {x1, y1, a1, h1, v1, s1};
      compare("small_frame", g1, e1);
    end
  end

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    pos0 = 0;
    pos1 = 0;

    // Reset, then the first enable lands on (0,0)
    repeat (3) drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    // Stall at (0,0): frame-start pulse must drop after one cycle
    repeat (5) drive(1'b0, 1'b0);
    // Continuous enable: more than two full lines of the large frame, many small frames
    repeat (3800) drive(1'b0, 1'b1);
    // Reset in the middle of a line at X=700
    for (int i = 0; i < 2000 && (pos0 % 1688) != 700; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    repeat (40) drive(1'b0, 1'b1);
    // Randomised enable pattern with rare reset pulses
    for (int i = 0; i < 20000; i++)
      drive(($urandom_range(0, 2999) == 0), ($urandom_range(0, 3) != 0));
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);

    // Let the monitor drain; leftover entries mean missed comparisons
    for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d/%0d pending required 0/0", q0.size(), q1.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/generatore_scansione.md
# generatore_scansione

Raster scan timing generator: walks a pixel position over a 1280x1024@60 frame and drives `X_CONTROLLO` / `Y_CONTROLLO` into every shape hit-test instance. It also produces the HSYNC, VSYNC, active-area and frame-start signals the display output path needs. It is the source end of the scan-coordinate interface. Shape blocks only compare against these coordinates, and they must gate their hit with `ATTIVO`.

## Interface
Parameters:
- `H_ATTIVO`, 1280, visible pixels per line
- `H_FRONT`, 48, horizontal front porch, pixels
- `H_SYNC`, 112, horizontal sync width, pixels
- `H_BACK`, 248, horizontal back porch, pixels
- `V_ATTIVO`, 1024, visible lines per frame
- `V_FRONT`, 1, vertical front porch, lines
- `V_SYNC`, 3, vertical sync width, lines
- `V_BACK`, 38, vertical back porch, lines

Ports:
- `CLK`  in  1  pixel-domain clock, rising edge
- `RST`  in  1  synchronous reset, active-high
- `ENABLE`  in  1  pixel tick; position advances only on CLK edges with ENABLE=1
- `X_CONTROLLO`  out  11  current horizontal count, 0..H_TOT-1
- `Y_CONTROLLO`  out  11  current vertical count, 0..V_TOT-1
- `ATTIVO`  out  1  current position is inside the visible area
- `HSYNC`  out  1  horizontal sync, polarity per Configuration
- `VSYNC`  out  1  vertical sync, polarity per Configuration
- `INIZIO_QUADRO`  out  1  one-CLK pulse on entry to position (0,0)

## Operation
- Derived totals: H_TOT = H_ATTIVO+H_FRONT+H_SYNC+H_BACK (1688); V_TOT = V_ATTIVO+V_FRONT+V_SYNC+V_BACK (1066).
- Both totals must be ≤ 2047. Elaboration fails otherwise.
- Horizontal counter:
  - increments on each ENABLE edge;
  - at H_TOT-1 it wraps to 0 and the vertical counter advances.
- Vertical counter:
  - wraps from V_TOT-1 to 0;
  - the wrap happens only together with a horizontal wrap.
- `X_CONTROLLO` / `Y_CONTROLLO` are the counter registers themselves. No offset is applied, and blanking values are reported raw.
- Decoded flags, as functions of the current (X, Y):
  - `ATTIVO` = X < H_ATTIVO and Y < V_ATTIVO
  - HSYNC asserted for H_ATTIVO+H_FRONT ≤ X < H_ATTIVO+H_FRONT+H_SYNC, i.e. 1328..1439
  - VSYNC asserted for V_ATTIVO+V_FRONT ≤ Y < V_ATTIVO+V_FRONT+V_SYNC, i.e. 1025..1027
  - VSYNC is independent of X.
- `INIZIO_QUADRO` is high for exactly the first CLK cycle in which the position equals (0,0).
  - It stays low on later stalled cycles at (0,0), i.e. while ENABLE=0.
- Reset state:
  - position (H_TOT-1, V_TOT-1), i.e. X=1687, Y=1065;
  - ATTIVO=0, HSYNC and VSYNC at their inactive level, INIZIO_QUADRO=0.
  - The first ENABLE after reset therefore lands on (0,0), with INIZIO_QUADRO=1 and ATTIVO=1.

## Timing
- All outputs are registered and change only on rising CLK.
- Flags are precomputed from the next-state counters, so they are always cycle-aligned with the X/Y values presented in the same cycle. No extra pipeline skew is allowed.
- Latency: an ENABLE sampled high at edge n makes the new position and its flags visible after edge n.
- ENABLE=0 freezes every output. Exception: INIZIO_QUADRO drops to 0 after one cycle.
- RST has priority over ENABLE. RST asserted mid-frame returns to the reset state on the next edge, whatever the position or ENABLE.
- A horizontal and vertical wrap on the same edge, from (1687,1065) to (0,0), is a single update: no intermediate (0,1065) is ever visible.
- ENABLE may toggle on every cycle with no restriction; a continuously high ENABLE is the normal case.

## Configuration
- Macro `GEN_SCANSIONE_SYNC_POS_EN`:
  - defined: HSYNC and VSYNC are active-high, and their inactive/reset level is 0;
  - undefined: both are active-low, and their inactive/reset level is 1.
- ATTIVO and INIZIO_QUADRO are always active-high.

## Test plan
- Reset then ENABLE=1 continuous:
  - first update gives X=0, Y=0, ATTIVO=1, INIZIO_QUADRO=1;
  - next update gives X=1, INIZIO_QUADRO=0.
- Line sweep:
  - ATTIVO falls on the update to X=1280;
  - HSYNC is asserted for exactly 112 updates, starting at X=1328;
  - the update after X=1687 gives X=0, Y=1.
- Full frame with ENABLE=1:
  - VSYNC is asserted for 3×1688 = 5064 consecutive updates, starting at (0,1025);
  - INIZIO_QUADRO repeats every 1688×1066 = 1,799,408 updates.
- ENABLE held low for 5 cycles at (0,0):
  - X, Y and the syncs are frozen;
  - INIZIO_QUADRO is high for one cycle only.
- RST pulsed while at (700,500) with ENABLE=1:
  - the next edge gives X=1687, Y=1065, ATTIVO=0, syncs inactive;
  - the frame then restarts at (0,0).
- Build with and without `GEN_SCANSIONE_SYNC_POS_EN`: at X=1400 the HSYNC levels are 1 and 0 respectively, and the reset levels are 0 and 1 respectively.
